// File: rtl/exp_pkg.sv
// Shared widths, the Q1.15 unity constant and the exp ROM content function
// for the softmax exp lookup / accumulate stage.
package exp_pkg;

    localparam int unsigned INT_W  = 3;
    localparam int unsigned FRAC_W = 3;
    localparam int unsigned FX_W   = INT_W + FRAC_W;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned ACC_W  = 24;

    localparam logic [15:0] ONE_Q15 = 16'h8000;

    // Fraction bits of the internal fixed-point arithmetic used to build the table.
    localparam int unsigned CALC_FRAC = 48;

    // round(exp(-k / 2^frac_w) * 2^(out_w-1)), round-half-up; the all-ones code is
    // the converter overflow marker and maps to 0. exp(-2^-frac_w) comes from a
    // Taylor series, then it is raised to the k-th power, all in Q.48 so that the
    // result is exact to well below one output LSB. Requires out_w <= 32.
    function automatic logic [31:0] exp_rom_val(input int unsigned k,
                                                input int unsigned int_w,
                                                input int unsigned frac_w,
                                                input int unsigned out_w);
        logic [127:0] one;
        logic [127:0] x_q;
        logic [127:0] term;
        logic [127:0] base;
        logic [127:0] acc;
        one = 128'd1 << CALC_FRAC;
        if (k == (32'd1 << (int_w + frac_w)) - 32'd1) begin
            return '0;
        end
        x_q  = one >> frac_w;
        term = one;
        base = one;
        for (int unsigned n = 1; n <= 24; n++) begin
            term = ((term * x_q) >> CALC_FRAC) / 128'(n);
            if (n[0]) begin
                base = base - term;
            end else begin
                base = base + term;
            end
        end
        acc = one;
        for (int unsigned i = 0; i < k; i++) begin
            acc = (acc * base) >> CALC_FRAC;
        end
        acc = (acc + (128'd1 << (CALC_FRAC - out_w))) >> (CALC_FRAC - out_w + 1);
        return acc[31:0];
    endfunction

endpackage

// File: rtl/exp_lut_rom.sv
// Combinational exp(-x) lookup table; contents are elaboration-time constants
// produced by exp_pkg::exp_rom_val.
module exp_lut_rom
    import exp_pkg::*;
#(
    parameter int unsigned INT_WIDTH  = INT_W,
    parameter int unsigned FRAC_WIDTH = FRAC_W,
    parameter int unsigned OUT_WIDTH  = OUT_W
) (
    input  logic [INT_WIDTH+FRAC_WIDTH-1:0] addr,
    output logic [OUT_WIDTH-1:0]            data
);

    localparam int unsigned AW    = INT_WIDTH + FRAC_WIDTH;
    localparam int unsigned DEPTH = 1 << AW;

    logic [OUT_WIDTH-1:0] rom_tbl [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        localparam logic [OUT_WIDTH-1:0] ENTRY =
            OUT_WIDTH'(exp_rom_val(k, INT_WIDTH, FRAC_WIDTH, OUT_WIDTH));
        assign rom_tbl[k] = ENTRY;
    end

    // Asynchronous table read.
    always_comb begin
        data = rom_tbl[addr];
    end

endmodule

// File: rtl/exp_lut_accum.sv
// Two-stage exp lookup pipeline with valid/ready on both sides and a saturating
// per-vector sum of the streamed exp values, strobed at vector end.
module exp_lut_accum
    import exp_pkg::*;
#(
    parameter int unsigned INT_WIDTH  = INT_W,
    parameter int unsigned FRAC_WIDTH = FRAC_W,
    parameter int unsigned OUT_WIDTH  = OUT_W,
    parameter int unsigned ACC_WIDTH  = ACC_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [INT_WIDTH+FRAC_WIDTH-1:0] in_fx,
    input  logic                            in_valid,
    input  logic                            in_last,
    output logic                            in_ready,
    output logic [OUT_WIDTH-1:0]            out_exp,
    output logic                            out_valid,
    output logic                            out_last,
    input  logic                            out_ready,
    output logic [ACC_WIDTH-1:0]            sum_out,
    output logic                            sum_valid
);

    localparam int unsigned FXW   = INT_WIDTH + FRAC_WIDTH;
    localparam int unsigned EXT_W = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;

    logic                 s1_valid_q, s1_valid_d;
    logic [FXW-1:0]       s1_fx_q, s1_fx_d;
    logic                 s1_last_q, s1_last_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0] s2_exp_q, s2_exp_d;
    logic                 s2_last_q, s2_last_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic                 sum_valid_q, sum_valid_d;

    logic [OUT_WIDTH-1:0] rom_data;
    logic                 advance;
    logic                 xfer;
    logic [EXT_W-1:0]     sum_ext;
    logic [ACC_WIDTH-1:0] sum_sat;

    exp_lut_rom #(
        .INT_WIDTH (INT_WIDTH),
        .FRAC_WIDTH(FRAC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_rom (
        .addr(s1_fx_q),
        .data(rom_data)
    );

    // Stall control and next state of both pipeline stages.
    always_comb begin
        advance    = !s2_valid_q || out_ready;
        in_ready   = advance || !s1_valid_q;
        s1_valid_d = s1_valid_q;
        s1_fx_d    = s1_fx_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_exp_d   = s2_exp_q;
        s2_last_d  = s2_last_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_fx_d   = in_fx;
                s1_last_d = in_last;
            end
        end
        if (advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_exp_d  = rom_data;
                s2_last_d = s1_last_q;
            end
        end
    end

    // Saturating accumulate on every output transfer; close the vector on last.
    always_comb begin
        xfer        = s2_valid_q && out_ready;
        sum_ext     = EXT_W'(acc_q) + EXT_W'(s2_exp_q);
        sum_sat     = (sum_ext[EXT_W-1:ACC_WIDTH] != '0) ? '1 : sum_ext[ACC_WIDTH-1:0];
        acc_d       = acc_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        if (xfer) begin
            if (s2_last_q) begin
                sum_d       = sum_sat;
                sum_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d = sum_sat;
            end
        end
    end

    // Pipeline, accumulator and sum registers with async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_fx_q     <= '0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_exp_q    <= '0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fx_q     <= s1_fx_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_exp_q    <= s2_exp_d;
            s2_last_q   <= s2_last_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign out_exp   = s2_exp_q;
    assign out_valid = s2_valid_q;
    assign out_last  = s2_last_q;
    assign sum_out   = sum_q;
    assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_exp_lut_accum.sv
// Scoreboard bench for exp_lut_accum: the driver pushes hand-computed expected
// exp values and vector sums, an independent monitor pops and compares them.
module tb_exp_lut_accum;
    import exp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  in_fx = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] out_exp;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic [23:0] sum_out;
    logic        sum_valid;

    logic [5:0]  in_fx_s = '0;
    logic        in_valid_s = 1'b0;
    logic        in_last_s = 1'b0;
    logic        in_ready_s;
    logic [15:0] out_exp_s;
    logic        out_valid_s;
    logic        out_last_s;
    logic        out_ready_s = 1'b1;
    logic [15:0] sum_out_s;
    logic        sum_valid_s;

    always #5 clk = ~clk;

    exp_lut_accum #(.INT_WIDTH(3), .FRAC_WIDTH(3), .OUT_WIDTH(16), .ACC_WIDTH(24)) dut (
        .clk(clk), .rst_n(rst_n), .in_fx(in_fx), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_exp(out_exp), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .sum_out(sum_out), .sum_valid(sum_valid)
    );

    exp_lut_accum #(.INT_WIDTH(3), .FRAC_WIDTH(3), .OUT_WIDTH(16), .ACC_WIDTH(16)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_fx(in_fx_s), .in_valid(in_valid_s), .in_last(in_last_s),
        .in_ready(in_ready_s), .out_exp(out_exp_s), .out_valid(out_valid_s), .out_last(out_last_s),
        .out_ready(out_ready_s), .sum_out(sum_out_s), .sum_valid(sum_valid_s)
    );

    typedef struct {
        logic [15:0] val;
        logic        last;
        int          cyc;
        bit          chk_lat;
    } exp_item_t;

    exp_item_t   exp_q[$];
    int unsigned sum_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          toggle_mode = 1'b0;
    bit          seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // out_ready: constant 1, or the 1,0,0,1 pattern while toggle_mode is set.
    initial begin
        logic [3:0] pat;
        int unsigned idx;
        pat = 4'b1001;
        idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mode) begin
                out_ready = pat[3 - (idx % 4)];
                idx++;
            end else begin
                out_ready = 1'b1;
                idx = 0;
            end
        end
    end

    // Monitor: ready rules, latency, output order and vector sums.
    initial begin
        exp_item_t it;
        int unsigned s;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!out_valid || out_ready) chk("in_ready_free", 64'(in_ready), 64'd1);
                if (!in_ready) chk("in_ready_stall", 64'({out_valid, out_ready}), 64'd2);
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 64'(out_exp), 64'hFFFF_FFFF);
                    end else begin
                        if (!seen && exp_q[0].chk_lat)
                            chk("latency", 64'(cyc - exp_q[0].cyc), 64'd2);
                        seen = 1'b1;
                        if (out_ready) begin
                            it = exp_q.pop_front();
                            seen = 1'b0;
                            chk("out_exp", 64'(out_exp), 64'(it.val));
                            chk("out_last", 64'(out_last), 64'(it.last));
                        end
                    end
                end
                if (sum_valid) begin
                    if (sum_q.size() == 0) begin
                        chk("unexpected_sum", 64'(sum_out), 64'hFFFF_FFFF);
                    end else begin
                        s = sum_q.pop_front();
                        chk("sum_out", 64'(sum_out), 64'(s));
                    end
                end
            end
        end
    end

    task automatic send(input logic [5:0] fx, input logic last, input logic [15:0] e);
        int n;
        bit ok;
        exp_item_t it;
        n = 0;
        ok = 1'b0;
        in_fx = fx;
        in_last = last;
        in_valid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                it.val = e;
                it.last = last;
                it.cyc = cyc;
                it.chk_lat = !toggle_mode;
                exp_q.push_back(it);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sum_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size() + sum_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bit got;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_exp", 64'(out_exp), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_sum_out", 64'(sum_out), 64'd0);
        chk("rst_sum_valid", 64'(sum_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Basic vector: 0, 1, 8, 16(last)
        sum_q.push_back(78176);
        send(6'd0, 1'b0, ONE_Q15);
        send(6'd1, 1'b0, 16'd28918);
        send(6'd8, 1'b0, 16'd12055);
        send(6'd16, 1'b1, 16'd4435);
        drain();

        // Overflow marker, single-element vector
        sum_q.push_back(0);
        send(6'h3F, 1'b1, 16'd0);
        drain();

        // Back-pressure with out_ready toggling 1,0,0,1
        toggle_mode = 1'b1;
        sum_q.push_back(127434);
        send(6'd0, 1'b0, 16'd32768);
        send(6'd8, 1'b0, 16'd12055);
        send(6'd16, 1'b0, 16'd4435);
        send(6'd1, 1'b0, 16'd28918);
        send(6'h3F, 1'b0, 16'd0);
        send(6'd0, 1'b0, 16'd32768);
        send(6'd8, 1'b0, 16'd12055);
        send(6'd16, 1'b1, 16'd4435);
        drain();
        toggle_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back vectors without a bubble
        sum_q.push_back(32768);
        sum_q.push_back(65536);
        send(6'd0, 1'b1, 16'd32768);
        send(6'd0, 1'b0, 16'd32768);
        send(6'd0, 1'b1, 16'd32768);
        drain();

        // Reset mid-vector: one element already summed, two in flight
        send(6'd0, 1'b0, 16'd32768);
        send(6'd1, 1'b0, 16'd28918);
        send(6'd8, 1'b0, 16'd12055);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_exp", 64'(out_exp), 64'd0);
        chk("midrst_sum_out", 64'(sum_out), 64'd0);
        chk("midrst_sum_valid", 64'(sum_valid), 64'd0);
        exp_q.delete();
        seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_midrst", 64'(in_ready), 64'd1);
        sum_q.push_back(12055);
        send(6'd8, 1'b1, 16'd12055);
        drain();

        // Saturation with a 16-bit accumulator: 3 x 1.0 clamps to 65535
        for (int i = 0; i < 3; i++) begin
            in_fx_s = 6'd0;
            in_last_s = (i == 2);
            in_valid_s = 1'b1;
            @(negedge clk);
            chk("sat_in_ready", 64'(in_ready_s), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid_s = 1'b0;
        in_last_s = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (out_valid_s) begin
                chk("sat_out_exp", 64'(out_exp_s), 64'd32768);
                chk("sat_out_last_seen", 64'(out_last_s === 1'bx), 64'd0);
            end
            if (sum_valid_s) got = 1'b1;
            n++;
        end
        chk("sat_sum_seen", 64'(got), 64'd1);
        chk("sat_sum_out", 64'(sum_out_s), 64'd65535);
        @(negedge clk);
        chk("sat_sum_strobe_one", 64'(sum_valid_s), 64'd0);
        chk("sat_sum_hold", 64'(sum_out_s), 64'd65535);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/exp_lut_accum.md
Name: exp_lut_accum

Overview:
- Downstream neighbour of the FP16-to-fixed converter in the softmax exp unit.
- Consumes the unsigned fixed-point magnitude |x - max|, where x ≤ max. Looks up exp(-|x|) in a ROM and streams one exp value per element.
- Accumulates the per-vector sum of exp values for the normalisation divider.
- Two-stage pipeline with a valid/ready handshake on input and output, plus a one-cycle sum strobe at end of vector.

Parameters:
- INT_WIDTH, 3, integer bits of input magnitude
- FRAC_WIDTH, 3, fraction bits of input magnitude
- OUT_WIDTH, 16, exp output width, unsigned Q1.(OUT_WIDTH-1)
- ACC_WIDTH, 24, sum accumulator width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_fx  in  INT_WIDTH+FRAC_WIDTH  magnitude code; all-ones is the converter overflow marker
- in_valid  in  1  in_fx valid
- in_last  in  1  marks last element of vector
- in_ready  out  1  stage can accept
- out_exp  out  OUT_WIDTH  exp(-in_fx/2^FRAC_WIDTH), Q1.15
- out_valid  out  1  out_exp valid
- out_last  out  1  last element of vector
- out_ready  in  1  consumer accepts
- sum_out  out  ACC_WIDTH  sum of out_exp over the vector
- sum_valid  out  1  one-cycle strobe

Behaviour:
- Reset (async, rst_n=0): all pipeline valids=0, out_exp=0, out_last=0, sum_out=0, sum_valid=0, accumulator=0.
  - Reset asserted mid-vector discards the partial vector and partial sum.
  - in_ready is 1 one cycle after reset release.
- Input handshake: accepted when in_valid & in_ready. Output handshake: transfer when out_valid & out_ready.
- Pipeline:
  - S1 registers in_fx and in_last.
  - S2 registers the ROM output and last flag; S2 drives the out_* ports.
  - Latency: 2 cycles from acceptance to out_valid with no stall.
  - Throughput: 1 element/cycle.
- Stall: advance = !out_valid | out_ready. in_ready = advance | !s1_valid.
  - S1 loads on advance or when empty.
  - Registers hold value and valid while stalled.
  - No data is lost or duplicated.
  - in_ready must not depend combinationally on in_valid.
- ROM contents:
  - entry[k] = round(exp(-k/2^FRAC_WIDTH) · 2^(OUT_WIDTH-1)), round-half-up.
  - Entry for the all-ones code is forced to 0 (overflow → exp underflow).
  - entry[0] = 32768 = 0x8000 (exactly 1.0).
- Accumulator:
  - On each output transfer: acc += out_exp, zero-extended, saturating at 2^ACC_WIDTH-1.
  - If the transfer carries out_last: sum_out <= acc + out_exp (saturated), sum_valid = 1 for exactly one cycle, and acc clears to 0 in the same cycle.
  - sum_valid is not back-pressured; sum_out holds until the next vector end.
- Boundaries:
  - A single-element vector (in_last on first element) gives sum = that exp.
  - Back-to-back vectors with no bubble: the first element of the next vector starts from acc = 0.
  - in_last is only meaningful when in_valid is 1.
- Combinational ROM read in S1→S2; no multi-cycle paths.

Decomposition:
- Shared package exp_pkg holds:
  - width localparams (FX_W = INT_WIDTH+FRAC_WIDTH, OUT_W, ACC_W)
  - the ROM content function exp_rom_val(k) used by RTL and bench
  - the constant ONE_Q15 = 16'h8000
- One sub-module, exp_lut_rom: combinational, parameterised by INT_WIDTH/FRAC_WIDTH/OUT_WIDTH; case/initial table generated from the package function.
- Top holds the pipeline registers, stall logic and accumulator.

Test Plan:
- Reset release, then stream fx = 0, 1, 8, 16 (last on 16) with out_ready=1:
  - out_exp = 32768, 28918, 12055, 4435, appearing 2 cycles after each acceptance.
  - sum_out = 78176 with sum_valid one cycle, aligned to the fourth transfer.
- Input fx = 6'h3F (overflow marker), single-element vector: out_exp = 0, sum_out = 0, sum_valid pulses.
- Stream 8 elements while toggling out_ready 1,0,0,1,…:
  - the output sequence matches the input order exactly, with no drops or duplicates.
  - in_ready deasserts only while S1 and S2 are both full and out_ready = 0.
- Back-to-back vectors {fx=0, last} and {fx=0, fx=0, last}: sum_out = 32768 then 65536, with no carry-over between vectors.
- With ACC_WIDTH = 16, stream three fx=0 elements then last: sum_out saturates at 65535.
- Assert rst_n low mid-vector after 2 accepted elements:
  - outputs and sum clear immediately (async).
  - A new vector {fx=8, last} yields sum_out = 12055.
